// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: each cycle decides whether the PC advances, whether
// IF/ID loads or takes a bubble, and which redirect source fetch applies.
// Request inputs are level-sensitive and are consumed in the cycle the matching
// enable/select is high; there is no separate acknowledge except trap_ack.
// Also sequences traps (issue then flush), holds on data-memory busy with a
// sticky watchdog, and counts accepted redirects.
module fetch_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             mem_busy,
    input  logic             jump_branch,
    input  logic             jump_target,
    input  logic             jump_reg,
    input  logic             trap_req,
    input  logic [31:0]      trap_vec,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             sel_branch,
    output logic             sel_target,
    output logic             sel_reg,
    output logic             sel_trap,
    output logic [31:0]      trap_pc,
    output logic             trap_ack,
    output logic [CNT_W-1:0] redirect_count,
    output logic             watchdog_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        TFLUSH = 2'd2
    } state_t;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0]      HOLD_LIMIT = 16'(HOLD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_n;
    logic        trap_pend;
    logic        trap_issue;
    logic [3:0]  flush_cnt;
    logic [15:0] hold_cnt;
    logic [15:0] hold_nxt;
    logic        hold_step;
    logic        eff_trap;

    assign state_dbg = state;

    // State register; reset aborts any flush or hold in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_n;
    end

    // Next state and Mealy control outputs; everything forced low in reset.
    always_comb begin
        state_n    = state;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        sel_branch = 1'b0;
        sel_target = 1'b0;
        sel_reg    = 1'b0;
        sel_trap   = 1'b0;
        trap_ack   = 1'b0;
        trap_issue = 1'b0;
        eff_trap   = trap_req | trap_pend;
        case (state)
            RUN: begin
                if (eff_trap && !mem_busy) begin
                    sel_trap   = 1'b1;
                    trap_ack   = 1'b1;
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    trap_issue = 1'b1;
                    state_n    = TFLUSH;
                end else if (mem_busy) begin
                    state_n = HOLD;
                end else if (stall_req) begin
                    // ID is held, so any jump stays asserted and is taken later.
                    pc_en   = 1'b0;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    sel_branch = jump_branch;
                    sel_target = jump_target & ~jump_branch;
                    sel_reg    = jump_reg & ~jump_branch & ~jump_target;
                end
            end
            HOLD: begin
                if (!mem_busy) state_n = RUN;
            end
            TFLUSH: begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                if (flush_cnt == 4'd0) state_n = RUN;
            end
            default: state_n = RUN;
        endcase
        if (!rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            sel_branch = 1'b0;
            sel_target = 1'b0;
            sel_reg    = 1'b0;
            sel_trap   = 1'b0;
            trap_ack   = 1'b0;
            trap_issue = 1'b0;
        end
    end

    // Trap capture: the first request wins until the trap is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_pend <= 1'b0;
            trap_pc   <= 32'd0;
        end else begin
            if (trap_req && !trap_pend) trap_pc <= trap_vec;
            if (trap_issue)    trap_pend <= 1'b0;
            else if (trap_req) trap_pend <= 1'b1;
        end
    end

    // Flush length counter, loaded on trap issue and run down in TFLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   flush_cnt <= 4'd0;
        else if (trap_issue)                        flush_cnt <= FLUSH_LOAD;
        else if (state == TFLUSH && flush_cnt != 0) flush_cnt <= flush_cnt - 4'd1;
    end

    // Hold run-length: starts at 1 on the busy cycle in RUN, saturates in HOLD.
    always_comb begin
        hold_step = ((state == RUN) && mem_busy) || (state == HOLD);
        hold_nxt  = 16'd1;
        if (state == HOLD) hold_nxt = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
    end

    // Hold counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt     <= 16'd0;
            watchdog_err <= 1'b0;
        end else if (hold_step) begin
            hold_cnt <= hold_nxt;
            if (hold_nxt >= HOLD_LIMIT) watchdog_err <= 1'b1;
        end
    end

    // Saturating count of cycles in which any redirect select is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) redirect_count <= '0;
        else if ((sel_branch | sel_target | sel_reg | sel_trap) && redirect_count != CNT_MAX)
            redirect_count <= redirect_count + CNT_ONE;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: decides each cycle whether the PC advances, whether the IF/ID register loads or is flushed, and which redirect source (branch, jump target, jump register, trap) the fetch stage applies.
- Sits between the ID/EX hazard logic, data-memory busy, the exception unit, and the fetch stage plus IF/ID pipeline register.
- Owns trap sequencing, memory-wait holds, a hold watchdog, and a redirect performance counter.

Parameters:
- FLUSH_CYCLES, 2: cycles spent in TFLUSH after a trap (covers instruction-ROM read latency); legal range 1..15.
- HOLD_TIMEOUT, 255: consecutive HOLD cycles at which watchdog_err sets; legal range 1..65535.
- CNT_W, 16: width of redirect_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- stall_req  input  1  load-use hazard from ID, level.
- mem_busy  input  1  data memory not ready; freezes the front end.
- jump_branch  input  1  taken branch resolved in ID.
- jump_target  input  1  J/JAL in ID.
- jump_reg  input  1  JR/JALR in ID.
- trap_req  input  1  exception request, 1-cycle pulse.
- trap_vec  input  32  handler address, sampled with trap_req.
- pc_en  output  1  PC register enable.
- ifid_en  output  1  IF/ID register enable.
- ifid_flush  output  1  loads a bubble into IF/ID; only asserted with ifid_en=1.
- sel_branch, sel_target, sel_reg, sel_trap  output  1 each  redirect selects to fetch, at most one high.
- trap_pc  output  32  latched trap vector (registered).
- trap_ack  output  1  high in the cycle sel_trap is asserted.
- redirect_count  output  CNT_W  accepted redirects, saturating.
- watchdog_err  output  1  sticky hold timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; trap_pend=0; trap_pc=0; counters=0; watchdog_err=0.
  - While rst=0, every combinational output is forced to 0.
- Control outputs are Mealy (state + current inputs). trap_pc, counters and flags are registered.
- Effective trap: t = trap_req | trap_pend.
- RUN, priority highest first:
  1. t & !mem_busy: sel_trap=1, trap_ack=1, pc_en=1, ifid_en=1, ifid_flush=1; trap_pend<=0; flush counter<=FLUSH_CYCLES-1; go to TFLUSH.
  2. mem_busy: pc_en=0, ifid_en=0; go to HOLD; hold counter<=1.
  3. stall_req: pc_en=0, ifid_en=0; jump_* are ignored (ID is held, so they stay asserted next cycle).
  4. Any jump_*: exactly one sel_* high with priority branch > target > reg; pc_en=1, ifid_en=1, no flush (delay slot is kept).
  5. Otherwise: pc_en=1, ifid_en=1.
- Trap capture: trap_req while trap_pend=0 latches trap_pc<=trap_vec and sets trap_pend, unless the trap is issued in that same cycle (trap_pc is still loaded).
  - trap_req while a trap is already pending is dropped; the first trap wins.
- HOLD: pc_en=0, ifid_en=0. The hold counter increments each cycle, saturating. When it reaches HOLD_TIMEOUT, watchdog_err<=1 (stays set until reset).
  - Leave to RUN when mem_busy=0. RUN rules apply in the following cycle, so a pending trap issues one cycle after busy drops.
- TFLUSH: pc_en=0, ifid_en=1, ifid_flush=1, all sel_*=0; jump_* and stall_req are ignored.
  - The flush counter decrements; at 0 go to RUN.
  - trap_req in TFLUSH is latched as pending and issues after TFLUSH ends.
  - mem_busy in TFLUSH is honoured only after TFLUSH ends.
- redirect_count increments by 1 in each cycle with any sel_*=1; it holds at all-ones.
- Reset mid-TFLUSH or mid-HOLD aborts immediately; pending trap and trap_pc are cleared.

Test Plan:
- Reset release, no requests -> pc_en=ifid_en=1 every cycle; all sel_*=0; redirect_count=0.
- jump_branch=jump_reg=1 for one cycle -> sel_branch=1 only, no flush, redirect_count=1.
- stall_req=1 with jump_target=1 for 2 cycles, then stall_req=0 -> pc_en=0 for 2 cycles, then sel_target=1 in cycle 3.
- trap_req with trap_vec=0x00000180 -> same cycle sel_trap=trap_ack=1; trap_pc=0x180; ifid_flush high for 1+2 cycles with pc_en=0 after the trap cycle; then RUN.
- mem_busy high 5 cycles with trap_req (vec 0x80) in busy cycle 2 and trap_req (vec 0x200) in cycle 3 -> pc_en=0 throughout; trap_pc=0x80; sel_trap one cycle after busy drops.
- HOLD_TIMEOUT=4, mem_busy high 6 cycles -> watchdog_err rises after the 4th hold cycle, stays 1 after busy drops, clears only on rst=0.
